// File: rtl/br_table_seq_pkg.sv
// Shared types and constants for the br_table immediate sequencer and its LEB128 decoder.
// Trap codes sit alongside the CPU's existing trap set so the core can report a br_table fault.
package br_table_seq_pkg;

    localparam int LEB_MAX_BYTES = 5;

    localparam logic [7:0] TRAP_NONE        = 8'h00;
    localparam logic [7:0] TRAP_UNREACHABLE = 8'h01;
    localparam logic [7:0] TRAP_MEM_OOB     = 8'h02;
    localparam logic [7:0] BR_TABLE_ERR     = 8'h03;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_CNT,
        S_DEC_CNT,
        S_RD_TGT,
        S_DEC_TGT,
        S_FIN,
        S_ERR
    } state_t;

endpackage

// File: rtl/leb128_u32.sv
// Combinational unsigned LEB128 decoder over a 5-byte window (byte 0 in bits [7:0]).
// Flags unterminated encodings and a 5th byte carrying value bits above bit 31.
module leb128_u32
    import br_table_seq_pkg::*;
(
    input  logic [8*LEB_MAX_BYTES-1:0] window,
    output logic [31:0]                value,
    output logic [2:0]                 len,
    output logic                       malformed
);

    logic found;

    always_comb begin
        value     = '0;
        len       = 3'(LEB_MAX_BYTES);
        malformed = 1'b0;
        found     = 1'b0;
        for (int b = 0; b < LEB_MAX_BYTES; b++) begin
            if (!found) begin
                value = value | (32'(window[8*b +: 7]) << (7*b));
                if (!window[8*b+7]) begin
                    found = 1'b1;
                    len   = 3'(b + 1);
                    // last byte may only contribute bits 31:28
                    if (b == LEB_MAX_BYTES-1)
                        malformed = (window[8*b+4 +: 3] != 3'd0);
                end
            end
        end
        if (!found)
            malformed = 1'b1;
    end

endmodule

// File: rtl/br_table_seq.sv
// Decodes the br_table label vector from ROM: picks the label for a runtime index and
// returns the address just past the default label, trapping on malformed or out-of-range reads.
module br_table_seq
    import br_table_seq_pkg::*;
#(
    parameter int MEM_DEPTH = 6,
    parameter int MEM_EXTRA = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [MEM_DEPTH:0]          table_pc,
    input  logic [31:0]                 index,
    output logic                        busy,
    output logic                        done,
    output logic [31:0]                 depth,
    output logic [MEM_DEPTH:0]          next_pc,
    output logic                        error,
    output logic [MEM_DEPTH:0]          mem_addr,
    output logic [MEM_EXTRA-1:0]        mem_extra,
    input  logic [(2**MEM_EXTRA)*8-1:0] mem_data,
    input  logic                        mem_error
);

    localparam int AW = MEM_DEPTH + 1;
    localparam int DW = (2**MEM_EXTRA) * 8;

    state_t        state, state_nxt;
    logic [AW-1:0] ptr;
    logic [31:0]   idx_q, count, sel, i_q;
    logic [31:0]   dec_value;
    logic [2:0]    dec_len;
    logic          dec_bad;
    logic [AW:0]   ptr_sum;
    logic          dec_err;
    logic          unused_data;

    leb128_u32 u_leb (
        .window    (mem_data[8*LEB_MAX_BYTES-1:0]),
        .value     (dec_value),
        .len       (dec_len),
        .malformed (dec_bad)
    );

    assign unused_data = ^mem_data[DW-1:8*LEB_MAX_BYTES];

    // carry out of the address width means the immediate ran past the end of ROM
    assign ptr_sum = {1'b0, ptr} + {{(AW-2){1'b0}}, dec_len};
    assign dec_err = mem_error | dec_bad | ptr_sum[AW];

    assign mem_addr  = ptr;
    assign mem_extra = MEM_EXTRA'(4);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_RD_CNT;
            S_RD_CNT:  state_nxt = S_DEC_CNT;
            S_DEC_CNT: state_nxt = dec_err ? S_ERR : S_RD_TGT;
            S_RD_TGT:  state_nxt = S_DEC_TGT;
            S_DEC_TGT: begin
                if (dec_err)           state_nxt = S_ERR;
                else if (i_q == count) state_nxt = S_FIN;
                else                   state_nxt = S_RD_TGT;
            end
            S_FIN:     state_nxt = S_IDLE;
            S_ERR:     state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE) && (state != S_FIN) && (state != S_ERR);
        done = (state == S_FIN) || (state == S_ERR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr     <= '0;
            idx_q   <= '0;
            count   <= '0;
            sel     <= '0;
            i_q     <= '0;
            depth   <= '0;
            next_pc <= '0;
            error   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    ptr   <= table_pc;
                    idx_q <= index;
                    error <= 1'b0;
                end
                S_DEC_CNT: begin
                    if (dec_err) error <= 1'b1;
                    else begin
                        count <= dec_value;
                        ptr   <= ptr_sum[AW-1:0];
                        i_q   <= '0;
                        // out-of-range index selects the default entry at position count
                        sel   <= (idx_q < dec_value) ? idx_q : dec_value;
                    end
                end
                S_DEC_TGT: begin
                    if (dec_err) error <= 1'b1;
                    else begin
                        if (i_q == sel)   depth   <= dec_value;
                        if (i_q == count) next_pc <= ptr_sum[AW-1:0];
                        ptr <= ptr_sum[AW-1:0];
                        i_q <= i_q + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
